riscv_core: RTL and testbench
=============================

Name: riscv_core

Overview:
- Single-cycle RV32I-subset processor: one instruction fetched, decoded, executed and retired per clock.
- Self-contained top level with instruction memory, register file, ALU, immediate generator, control decoder and data memory.
- No functional I/O besides clock and reset; benches load the program and read architectural state through fixed hierarchical names.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit instruction words.
- DMEM_DEPTH, 256, number of 32-bit data words.
- RESET_PC, 32'h0000_0000, PC value while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-high reset. The name is kept for codebase consistency; 1 = reset asserted.

Behaviour:
- Required hierarchy (benches depend on these names):
  - Instruction memory is instance Instr_Mem, holding array mem[0:IMEM_DEPTH-1] of 32-bit words. It is loadable by $readmemh, has no write port, and is not cleared by reset.
  - Register file is instance Reg, holding array regfile[0:31] of 32-bit words.
- Reset:
  - While rst_n=1: PC=RESET_PC and all regfile entries=0, asynchronously. Data memory is not cleared.
  - First instruction executes on the first rising edge after rst_n falls.
- Fetch:
  - Instruction = mem[PC[31:2]], combinational. PC[1:0] ignored.
  - PC beyond IMEM_DEPTH wraps modulo depth.
- Register file:
  - Two combinational read ports, one write port on the rising edge.
  - x0 reads 0 always; writes to x0 are discarded.
  - Read-during-write in the same cycle returns the old value.
- Supported instructions (all others: no register/memory write, PC+4):
  - R-type: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - I-type ALU: ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI.
  - LW, SW: word only; address = rs1+sext(imm), word index = addr[31:2] modulo DMEM_DEPTH.
  - BEQ, BNE, BLT, BGE.
  - JAL, JALR: rd <= PC+4; JALR target LSB cleared.
  - LUI, AUIPC.
- Arithmetic:
  - 32-bit, wrap-around, no overflow detection.
  - Shift amount = low 5 bits of operand.
  - SLT/BLT/BGE signed; SLTU unsigned.
  - Immediates sign-extended per RV32I I/S/B/J/U formats.
- Data memory:
  - Combinational read.
  - Write on the rising edge when SW is executing.
  - LW after SW to the same address in the next cycle returns the stored value.
- Next PC: taken branch/JAL = PC+imm; JALR = (rs1+imm)&~1; otherwise PC+4. Updated every rising edge when not in reset.
- Reset mid-run: PC and registers return to 0 immediately; execution restarts at RESET_PC after release.

Test Plan:
- Load "addi x1,x0,5; addi x10,x0,7; add x31,x1,x10"; reset 20 ns (10 ns clock) -> after 3 edges x1=5, x10=7, x31=12, all other registers 0.
- "addi x1,x0,-1; srli x10,x1,28; srai x31,x1,28" -> x1=0xFFFFFFFF, x10=15, x31=0xFFFFFFFF.
- "addi x1,x0,42; sw x1,8(x0); lw x10,8(x0)" -> x10=42; "addi x0,x0,9" leaves x0=0.
- Countdown loop "addi x1,x0,3; addi x10,x10,1; addi x1,x1,-1; bne x1,x0,-8" -> after loop x1=0, x10=3, PC=16.
- "jal x31,8" at PC 0 -> x31=4, PC=8; skipped instruction has no effect.
- Assert reset mid-program -> PC=0 and x1=x10=x31=0 within the same cycle; program reruns identically after release.

Source files
------------

// File: rtl/riscv_core.sv
// Single-cycle RV32I-subset core: fetch, decode, execute and retire one instruction per clock.
// The instruction and data memories, register file and PC all live inside this top level.

module riscv_imem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   instr_o
);
  // Filled externally by the bench; there is no write port and no reset.
  logic [31:0] mem [0:DEPTH-1];

  assign instr_o = mem[addr_i];
endmodule

module riscv_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o
);
  logic [31:0] regfile [0:31];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regfile[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : regfile[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : regfile[raddr_b_i];
endmodule

module riscv_core #(
  parameter int          IMEM_DEPTH = 256,
  parameter int          DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic rst_n
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] instr;
  logic [31:0] dmem_q [0:DMEM_DEPTH-1];

  riscv_imem #(.DEPTH(IMEM_DEPTH)) Instr_Mem (
    .addr_i  (pc_q[IAW+1:2]),
    .instr_o (instr)
  );

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1_a, rs2_a;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1_a  = instr[19:15];
  assign rs2_a  = instr[24:20];
  assign funct7 = instr[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

  logic        rf_we;
  logic [31:0] rf_wdata, rs1_v, rs2_v;

  riscv_regfile Reg (
    .clk       (clk),
    .rst       (rst_n),
    .we_i      (rf_we),
    .waddr_i   (rd),
    .wdata_i   (rf_wdata),
    .raddr_a_i (rs1_a),
    .raddr_b_i (rs2_a),
    .rdata_a_o (rs1_v),
    .rdata_b_o (rs2_v)
  );

  // Only funct7 = 0000000, or 0100000 on the SUB/SRA slots, names a real R-type op.
  logic is_r, r_valid, i_valid;
  assign is_r    = (opcode == OP_R);
  assign r_valid = (funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
  assign i_valid = (funct3 == 3'b001) ? (funct7 == 7'b0000000) :
                   (funct3 == 3'b101) ? ((funct7 == 7'b0000000) || (funct7 == 7'b0100000)) :
                   1'b1;

  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_res;

  always_comb begin
    alu_b = is_r ? rs2_v : imm_i;
    case (funct3)
      3'b000:  alu_op = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_SUB:  alu_res = rs1_v - alu_b;
      ALU_AND:  alu_res = rs1_v & alu_b;
      ALU_OR:   alu_res = rs1_v | alu_b;
      ALU_XOR:  alu_res = rs1_v ^ alu_b;
      ALU_SLL:  alu_res = rs1_v << alu_b[4:0];
      ALU_SRL:  alu_res = rs1_v >> alu_b[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(rs1_v) >>> alu_b[4:0]);
      ALU_SLT:  alu_res = {31'b0, $signed(rs1_v) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'b0, rs1_v < alu_b};
      default:  alu_res = rs1_v + alu_b;
    endcase
  end

  logic        br_taken, dmem_we;
  logic [31:0] mem_addr, dmem_rdata;
  logic [DAW-1:0] dmem_idx;
  logic [1+32-DAW-2:0] unused_addr_bits;

  assign mem_addr         = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign dmem_idx         = mem_addr[DAW+1:2];
  assign unused_addr_bits = {mem_addr[1:0], mem_addr[31:DAW+2]};
  assign dmem_rdata       = dmem_q[dmem_idx];
  assign pc_plus4         = pc_q + 32'd4;

  always_comb begin
    case (funct3)
      3'b000:  br_taken = (rs1_v == rs2_v);
      3'b001:  br_taken = (rs1_v != rs2_v);
      3'b100:  br_taken = ($signed(rs1_v) < $signed(rs2_v));
      3'b101:  br_taken = !($signed(rs1_v) < $signed(rs2_v));
      default: br_taken = 1'b0;
    endcase
  end

  // Unsupported encodings fall through with no writes and a plain PC+4.
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    dmem_we  = 1'b0;
    pc_d     = pc_plus4;
    case (opcode)
      OP_R:      rf_we = r_valid;
      OP_I:      rf_we = i_valid;
      OP_LOAD: begin
        rf_we    = (funct3 == 3'b010);
        rf_wdata = dmem_rdata;
      end
      OP_STORE:  dmem_we = (funct3 == 3'b010);
      OP_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
      OP_JAL: begin
        rf_we    = 1'b1;
        rf_wdata = pc_plus4;
        pc_d     = pc_q + imm_j;
      end
      OP_JALR: if (funct3 == 3'b000) begin
        rf_we    = 1'b1;
        rf_wdata = pc_plus4;
        pc_d     = (rs1_v + imm_i) & ~32'd1;
      end
      OP_LUI: begin
        rf_we    = 1'b1;
        rf_wdata = imm_u;
      end
      OP_AUIPC: begin
        rf_we    = 1'b1;
        rf_wdata = pc_q + imm_u;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  // Data memory survives reset.
  always_ff @(posedge clk) begin
    if (dmem_we && !rst_n) dmem_q[dmem_idx] <= rs2_v;
  end
endmodule

// File: tb/tb_riscv_core.sv
// Directed-program bench for riscv_core: loads small programs through Instr_Mem.mem
// and checks PC and register state after a known number of clock edges.

module tb_riscv_core;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  riscv_core dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return i_t(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] sw_t(input logic [11:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] rd,
                                      input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  // Holds reset for two cycles and clears instruction memory; caller then loads a program.
  task automatic start_prog();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 256; k++) dut.Instr_Mem.mem[k] = 32'h0000_0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input int edges);
    rst_n = 1'b0;
    repeat (edges) @(negedge clk);
  endtask

  task automatic test_reset();
    start_prog();
    if (dut.pc_q !== 32'h0) begin
      n_err++; $display("FAIL reset_pc: got %h want %h", dut.pc_q, 32'h0);
    end
    n_cmp++;
    for (int r = 0; r < 32; r++) begin
      if (dut.Reg.regfile[r] !== 32'h0) begin
        n_err++; $display("FAIL reset_x%0d: got %h want %h", r, dut.Reg.regfile[r], 32'h0);
      end
      n_cmp++;
    end
  endtask

  task automatic test_add();
    logic [31:0] exp_r [32];
    start_prog();
    dut.Instr_Mem.mem[0] = addi(5'd1, 5'd0, 12'd5);
    dut.Instr_Mem.mem[1] = addi(5'd10, 5'd0, 12'd7);
    dut.Instr_Mem.mem[2] = r_t(7'b0000000, 5'd10, 5'd1, 3'b000, 5'd31);
    run(3);
    for (int r = 0; r < 32; r++) exp_r[r] = 32'h0;
    exp_r[1] = 32'd5; exp_r[10] = 32'd7; exp_r[31] = 32'd12;
    for (int r = 0; r < 32; r++) begin
      if (dut.Reg.regfile[r] !== exp_r[r]) begin
        n_err++; $display("FAIL add_x%0d: got %h want %h", r, dut.Reg.regfile[r], exp_r[r]);
      end
      n_cmp++;
    end
    if (dut.pc_q !== 32'd12) begin
      n_err++; $display("FAIL add_pc: got %h want %h", dut.pc_q, 32'd12);
    end
    n_cmp++;
  endtask

  task automatic test_shift();
    start_prog();
    dut.Instr_Mem.mem[0] = addi(5'd1, 5'd0, 12'hFFF);
    dut.Instr_Mem.mem[1] = i_t(12'h01C, 5'd1, 3'b101, 5'd10, 7'b0010011);
    dut.Instr_Mem.mem[2] = i_t(12'h41C, 5'd1, 3'b101, 5'd31, 7'b0010011);
    run(3);
    if (dut.Reg.regfile[1] !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL shift_x1: got %h want %h", dut.Reg.regfile[1], 32'hFFFF_FFFF);
    end
    n_cmp++;
    if (dut.Reg.regfile[10] !== 32'd15) begin
      n_err++; $display("FAIL srli_x10: got %h want %h", dut.Reg.regfile[10], 32'd15);
    end
    n_cmp++;
    if (dut.Reg.regfile[31] !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL srai_x31: got %h want %h", dut.Reg.regfile[31], 32'hFFFF_FFFF);
    end
    n_cmp++;
  endtask

  task automatic test_rtype();
    start_prog();
    dut.Instr_Mem.mem[0]  = addi(5'd1, 5'd0, 12'hFF8);
    dut.Instr_Mem.mem[1]  = addi(5'd2, 5'd0, 12'd3);
    dut.Instr_Mem.mem[2]  = r_t(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd3);
    dut.Instr_Mem.mem[3]  = r_t(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd4);
    dut.Instr_Mem.mem[4]  = r_t(7'b0000000, 5'd2, 5'd1, 3'b011, 5'd5);
    dut.Instr_Mem.mem[5]  = r_t(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd6);
    dut.Instr_Mem.mem[6]  = r_t(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd7);
    dut.Instr_Mem.mem[7]  = r_t(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd8);
    dut.Instr_Mem.mem[8]  = r_t(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd9);
    dut.Instr_Mem.mem[9]  = r_t(7'b0000000, 5'd2, 5'd1, 3'b101, 5'd11);
    dut.Instr_Mem.mem[10] = r_t(7'b0000000, 5'd2, 5'd2, 3'b001, 5'd12);
    run(11);
    begin
      logic [31:0] exp_v [13];
      exp_v[3] = 32'd11;         exp_v[4]  = 32'd1;          exp_v[5]  = 32'd0;
      exp_v[6] = 32'hFFFF_FFFB;  exp_v[7]  = 32'd0;          exp_v[8]  = 32'hFFFF_FFFB;
      exp_v[9] = 32'hFFFF_FFFF;  exp_v[11] = 32'h1FFF_FFFF;  exp_v[12] = 32'd24;
      exp_v[10] = 32'd0;
      for (int r = 3; r <= 12; r++) begin
        if (dut.Reg.regfile[r] !== exp_v[r]) begin
          n_err++; $display("FAIL rtype_x%0d: got %h want %h", r, dut.Reg.regfile[r], exp_v[r]);
        end
        n_cmp++;
      end
    end
  endtask

  task automatic test_mem();
    start_prog();
    dut.Instr_Mem.mem[0] = addi(5'd1, 5'd0, 12'd42);
    dut.Instr_Mem.mem[1] = sw_t(12'd8, 5'd1, 5'd0);
    dut.Instr_Mem.mem[2] = i_t(12'd8, 5'd0, 3'b010, 5'd10, 7'b0000011);
    dut.Instr_Mem.mem[3] = addi(5'd0, 5'd0, 12'd9);
    run(4);
    if (dut.Reg.regfile[10] !== 32'd42) begin
      n_err++; $display("FAIL lw_after_sw: got %h want %h", dut.Reg.regfile[10], 32'd42);
    end
    n_cmp++;
    if (dut.Reg.regfile[0] !== 32'd0) begin
      n_err++; $display("FAIL x0_write: got %h want %h", dut.Reg.regfile[0], 32'd0);
    end
    n_cmp++;
  endtask

  task automatic test_loop();
    start_prog();
    dut.Instr_Mem.mem[0] = addi(5'd1, 5'd0, 12'd3);
    dut.Instr_Mem.mem[1] = addi(5'd10, 5'd10, 12'd1);
    dut.Instr_Mem.mem[2] = addi(5'd1, 5'd1, 12'hFFF);
    dut.Instr_Mem.mem[3] = b_t(13'h1FF8, 5'd0, 5'd1, 3'b001);
    run(4);
    if (dut.pc_q !== 32'd4 || dut.Reg.regfile[1] !== 32'd2 || dut.Reg.regfile[10] !== 32'd1) begin
      n_err++; $display("FAIL loop_iter1: got pc=%h x1=%h x10=%h want pc=4 x1=2 x10=1",
                        dut.pc_q, dut.Reg.regfile[1], dut.Reg.regfile[10]);
    end
    n_cmp++;
    repeat (6) @(negedge clk);
    if (dut.pc_q !== 32'd16) begin
      n_err++; $display("FAIL loop_pc: got %h want %h", dut.pc_q, 32'd16);
    end
    n_cmp++;
    if (dut.Reg.regfile[1] !== 32'd0) begin
      n_err++; $display("FAIL loop_x1: got %h want %h", dut.Reg.regfile[1], 32'd0);
    end
    n_cmp++;
    if (dut.Reg.regfile[10] !== 32'd3) begin
      n_err++; $display("FAIL loop_x10: got %h want %h", dut.Reg.regfile[10], 32'd3);
    end
    n_cmp++;
  endtask

  task automatic test_jal();
    start_prog();
    dut.Instr_Mem.mem[0] = j_t(21'd8, 5'd31);
    dut.Instr_Mem.mem[1] = addi(5'd1, 5'd0, 12'd99);
    dut.Instr_Mem.mem[2] = addi(5'd10, 5'd0, 12'd1);
    run(1);
    if (dut.pc_q !== 32'd8 || dut.Reg.regfile[31] !== 32'd4) begin
      n_err++; $display("FAIL jal_link: got pc=%h x31=%h want pc=8 x31=4",
                        dut.pc_q, dut.Reg.regfile[31]);
    end
    n_cmp++;
    @(negedge clk);
    if (dut.Reg.regfile[1] !== 32'd0 || dut.Reg.regfile[10] !== 32'd1 || dut.pc_q !== 32'd12) begin
      n_err++; $display("FAIL jal_skip: got x1=%h x10=%h pc=%h want x1=0 x10=1 pc=c",
                        dut.Reg.regfile[1], dut.Reg.regfile[10], dut.pc_q);
    end
    n_cmp++;
  endtask

  task automatic test_ctrl();
    logic [31:0] exp_v [9];
    start_prog();
    dut.Instr_Mem.mem[0]  = u_t(20'h12345, 5'd1, 7'b0110111);
    dut.Instr_Mem.mem[1]  = u_t(20'h00001, 5'd2, 7'b0010111);
    dut.Instr_Mem.mem[2]  = addi(5'd3, 5'd0, 12'd21);
    dut.Instr_Mem.mem[3]  = i_t(12'd0, 5'd3, 3'b000, 5'd4, 7'b1100111);
    dut.Instr_Mem.mem[4]  = addi(5'd5, 5'd0, 12'd1);
    dut.Instr_Mem.mem[5]  = b_t(13'd8, 5'd3, 5'd1, 3'b100);
    dut.Instr_Mem.mem[6]  = b_t(13'd8, 5'd3, 5'd1, 3'b101);
    dut.Instr_Mem.mem[7]  = addi(5'd6, 5'd0, 12'd1);
    dut.Instr_Mem.mem[8]  = b_t(13'd8, 5'd0, 5'd0, 3'b000);
    dut.Instr_Mem.mem[9]  = addi(5'd7, 5'd0, 12'd1);
    dut.Instr_Mem.mem[10] = addi(5'd8, 5'd0, 12'd2);
    run(8);
    exp_v[1] = 32'h1234_5000; exp_v[2] = 32'h0000_1004; exp_v[3] = 32'd21;
    exp_v[4] = 32'd16;        exp_v[5] = 32'd0;         exp_v[6] = 32'd0;
    exp_v[7] = 32'd0;         exp_v[8] = 32'd2;         exp_v[0] = 32'd0;
    for (int r = 1; r <= 8; r++) begin
      if (dut.Reg.regfile[r] !== exp_v[r]) begin
        n_err++; $display("FAIL ctrl_x%0d: got %h want %h", r, dut.Reg.regfile[r], exp_v[r]);
      end
      n_cmp++;
    end
    if (dut.pc_q !== 32'd44) begin
      n_err++; $display("FAIL ctrl_pc: got %h want %h", dut.pc_q, 32'd44);
    end
    n_cmp++;
  endtask

  task automatic test_pc_wrap();
    start_prog();
    dut.Instr_Mem.mem[0]   = j_t(21'd1020, 5'd0);
    dut.Instr_Mem.mem[255] = addi(5'd1, 5'd1, 12'd1);
    run(2);
    if (dut.pc_q !== 32'd1024 || dut.Reg.regfile[1] !== 32'd1) begin
      n_err++; $display("FAIL wrap_first: got pc=%h x1=%h want pc=400 x1=1",
                        dut.pc_q, dut.Reg.regfile[1]);
    end
    n_cmp++;
    repeat (2) @(negedge clk);
    if (dut.Reg.regfile[1] !== 32'd2) begin
      n_err++; $display("FAIL wrap_second: got %h want %h", dut.Reg.regfile[1], 32'd2);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    start_prog();
    dut.Instr_Mem.mem[0] = addi(5'd1, 5'd0, 12'd5);
    dut.Instr_Mem.mem[1] = addi(5'd10, 5'd0, 12'd7);
    dut.Instr_Mem.mem[2] = r_t(7'b0000000, 5'd10, 5'd1, 3'b000, 5'd31);
    run(2);
    if (dut.Reg.regfile[10] !== 32'd7) begin
      n_err++; $display("FAIL mid_before: got %h want %h", dut.Reg.regfile[10], 32'd7);
    end
    n_cmp++;
    rst_n = 1'b1;
    #1;
    if (dut.pc_q !== 32'd0 || dut.Reg.regfile[1] !== 32'd0 ||
        dut.Reg.regfile[10] !== 32'd0 || dut.Reg.regfile[31] !== 32'd0) begin
      n_err++; $display("FAIL mid_async: got pc=%h x1=%h x10=%h x31=%h want all 0",
                        dut.pc_q, dut.Reg.regfile[1], dut.Reg.regfile[10], dut.Reg.regfile[31]);
    end
    n_cmp++;
    repeat (2) @(negedge clk);
    if (dut.pc_q !== 32'd0) begin
      n_err++; $display("FAIL mid_hold: got %h want %h", dut.pc_q, 32'd0);
    end
    n_cmp++;
    run(3);
    if (dut.Reg.regfile[1] !== 32'd5 || dut.Reg.regfile[10] !== 32'd7 ||
        dut.Reg.regfile[31] !== 32'd12 || dut.pc_q !== 32'd12) begin
      n_err++; $display("FAIL mid_rerun: got x1=%h x10=%h x31=%h pc=%h want 5 7 c c",
                        dut.Reg.regfile[1], dut.Reg.regfile[10], dut.Reg.regfile[31], dut.pc_q);
    end
    n_cmp++;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    test_reset();
    test_add();
    test_shift();
    test_rtype();
    test_mem();
    test_loop();
    test_jal();
    test_ctrl();
    test_pc_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
